// File: rtl/ins_fetch_if.sv
// ins_fetch_if: fetch controller bundle toward insMem and the decode stage.
interface ins_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              start;
    logic              halt;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_l;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              busy;

    modport master (
        input  start, halt, redirect, redirect_pc, mem_q, inst_ready,
        output mem_l, mem_addr, inst, inst_pc, inst_valid, busy
    );

    modport slave (
        output start, halt, redirect, redirect_pc, mem_q, inst_ready,
        input  mem_l, mem_addr, inst, inst_pc, inst_valid, busy
    );
endinterface

// File: rtl/ins_fetch_ctrl.sv
// ins_fetch_ctrl: owns the PC, strobes insMem init, streams one instruction per cycle to decode.
module ins_fetch_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RESET_PC    = 0,
    parameter int PC_STEP     = 1,
    parameter int INIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    ins_fetch_if.master  f
);
    localparam int CNT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_valid;
    logic              w_capture, w_redir;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_redir   = 1'b0;
        case (r_state)
            IDLE:  w_next = f.start ? INIT : IDLE;
            INIT:  w_next = (r_cnt == CNT_W'(INIT_CYCLES - 1)) ? RUN : INIT;
            RUN: begin
                w_redir   = f.redirect;
                w_next    = f.halt ? DRAIN : RUN;
                w_capture = !f.halt && !f.redirect && (!r_valid || f.inst_ready);
            end
            DRAIN: begin
                w_redir = f.redirect;
                w_next  = r_valid ? DRAIN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pc      <= ADDR_W'(RESET_PC);
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == INIT) ? r_cnt + CNT_W'(1) : '0;
            // redirect flushes the entry even if decode is ready this cycle
            if (w_redir) begin
                r_pc    <= f.redirect_pc;
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_inst    <= f.mem_q;
                r_inst_pc <= r_pc;
                r_valid   <= 1'b1;
                r_pc      <= r_pc + ADDR_W'(PC_STEP);
            end else if (r_state == DRAIN && f.inst_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign f.mem_l      = (r_state == INIT);
    assign f.busy       = (r_state != IDLE);
    assign f.mem_addr   = r_pc;
    assign f.inst       = r_inst;
    assign f.inst_pc    = r_inst_pc;
    assign f.inst_valid = r_valid;
endmodule

// File: doc/ins_fetch_ctrl.md
# ins_fetch_ctrl

Instruction-fetch controller that sequences the instruction memory (`insMem`) for the processor. It owns the program counter and drives the memory's load strobe during an initialisation phase. It then streams one instruction per cycle into a single-entry output register with a valid/ready handshake toward decode. It supports PC redirects (branch/jump) and a halt/drain sequence, and sits between `insMem` and the decode stage.

## Interface
- `ADDR_W`, 32, width of PC and memory address.
- `DATA_W`, 32, instruction width; matches `insMem` `q`.
- `RESET_PC`, 0, PC value after reset.
- `PC_STEP`, 1, PC increment per fetch; memory is word-indexed.
- `INIT_CYCLES`, 1, cycles `mem_l` is held high after `start`; legal range is ≥1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin or resume fetching; sampled only in IDLE.
- `halt`  in  1  stop issuing fetches and drain; sampled only in RUN.
- `redirect`  in  1  replace the PC and flush the output register; sampled in RUN.
- `redirect_pc`  in  ADDR_W  new PC, used when `redirect` is 1.
- `mem_l`  out  1  load/init strobe to `insMem` `l`.
- `mem_addr`  out  ADDR_W  address to `insMem`; always equals the current `pc`.
- `mem_q`  in  DATA_W  `insMem` read data; combinational function of `mem_addr`.
- `inst`  out  DATA_W  fetched instruction.
- `inst_pc`  out  ADDR_W  address `inst` was read from.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid entry.
- `inst_ready`  in  1  decode accepts the entry when `inst_valid` and `inst_ready` are both 1.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, INIT, RUN, DRAIN. Encoding is free.
- **Reset values** (asynchronous, effective immediately): state=IDLE, `pc`=RESET_PC, `inst`=0, `inst_pc`=0, `inst_valid`=0, init counter=0, `mem_l`=0, `busy`=0.
- **IDLE:**
  - `start`=1 → go to INIT and clear the init counter.
  - `pc` is held, so a later `start` resumes at the stored PC.
- **INIT:**
  - `mem_l`=1; it is decoded from the state register, so it is glitch-free.
  - The counter increments each cycle. After INIT_CYCLES cycles in INIT, go to RUN.
  - Input `redirect` is ignored.
- **RUN, capture condition** = (`!inst_valid` || `inst_ready`):
  - When capture is true: `inst`←`mem_q`, `inst_pc`←`pc`, `inst_valid`←1, `pc`←`pc`+PC_STEP.
  - When capture is false: all registers hold (stall), and `mem_addr` stays at `pc`.
- **RUN, redirect=1:** has priority over capture.
  - `pc`←`redirect_pc`, `inst_valid`←0, `inst`/`inst_pc` hold.
  - The flushed entry is not considered accepted, even if `inst_ready`=1.
- **RUN, halt=1:** go to DRAIN. No capture happens that cycle.
  - If `redirect` is also 1, `pc`←`redirect_pc` and `inst_valid`←0 apply too.
- **DRAIN:**
  - No new captures.
  - If `inst_valid` && `inst_ready`, then `inst_valid`←0.
  - When `inst_valid` is 0 (at the start of a cycle, or once it is cleared), go to IDLE.
  - `redirect` in DRAIN updates `pc` and clears `inst_valid`.
- **Arithmetic:** `pc`+PC_STEP is computed modulo 2^ADDR_W. An all-ones `pc` wraps to 0 with no error.
- **Reset mid-operation:** any state returns to IDLE and any in-flight instruction is discarded.

## Timing
- `start` sampled at edge E0 → `mem_l`=1 for cycles E0..E0+INIT_CYCLES-1; state=RUN after edge E0+INIT_CYCLES.
- First `inst_valid`=1 after edge E0+INIT_CYCLES+1, carrying `mem_q` at RESET_PC.
- **Throughput:** 1 instruction/cycle while `inst_ready`=1. A captured entry is visible one edge after its address was driven.
- **Backpressure:** with `inst_ready`=0, `inst`, `inst_pc` and `pc` are stable and no instruction is skipped or duplicated.
- **Redirect:** asserted at edge R → `inst_valid`=0 after R; the instruction from `redirect_pc` is valid after R+1 (one bubble).
- **Halt:** from RUN with `inst_valid`=0 → IDLE two edges later. With an unaccepted entry, IDLE follows the accepting edge by one edge.
- `busy` is registered-state decoded: 1 from the edge after `start` until IDLE is re-entered.

## Test plan
Memory model for all scenarios: `mem_q` = 30 + `mem_addr`.

- **Reset and start:** reset, then `start`, with `inst_ready`=1 → `mem_l` is high for exactly 1 cycle, then `inst`=30/`inst_pc`=0, 31/1, 32/2 on consecutive cycles.
- **Backpressure:** `inst_ready`=0 for 3 cycles while `inst`=31 → `inst` stays 31, `inst_pc` stays 1, `pc` stays 2; after release the next entries are 32 and 33, none missing.
- **Redirect:** `redirect`=1 with `redirect_pc`=100 while `inst`=32 is valid → one cycle with `inst_valid`=0, then `inst`=130/`inst_pc`=100, then 131/101.
- **Halt with stalled entry:** `halt` with `inst_ready`=0 and `inst`=33 valid → state DRAIN, `inst` held; raise `inst_ready` → accepted, `inst_valid`=0, `busy`=0 next cycle; a later `start` resumes at PC 4 (`inst`=34) after INIT.
- **Wrap-around:** set `ADDR_W`=4 and redirect to 15 → `inst_pc` sequence 15, 0, 1 with `inst` 45, 30, 31.
- **Async reset mid-RUN:** pulse `rst` between edges while streaming → `inst_valid`, `busy` and `mem_l` drop immediately without a clock edge, and `pc` returns to RESET_PC.
